pw_trigger_sequencer: RTL and testbench

Trigger sequencer between `pw_pattern_matcher` and the trigger output stage, clocked on `fe_clk`. It arms the matcher on a software arm edge and waits for a match pulse. It then emits a programmable train of trigger pulses (delay, width, gap, count) and disarms. Counts completed sequences for status readback.

---
 rtl/pw_trigger_sequencer_if.sv | 56 +++++
 rtl/pw_trigger_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pw_trigger_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pw_trigger_sequencer_if.sv
// pw_trigger_sequencer_if: matcher/trigger-stage signal bundle for pw_trigger_sequencer.
// Optional macro PW_TRIG_TIMEOUT_EN adds I_timeout/O_timeout.
// Ports (as seen by the sequencer through modport slave):
//   I_arm            software arm level, synchronous to fe_clk
//   I_match_trigger  single-cycle match pulse from pw_pattern_matcher
//   I_delay          cycles from match to first pulse
//   I_width          pulse high time (0 behaves as 1)
//   I_gap            low time between pulses (0 behaves as 1)
//   I_num_pulses     pulses per sequence (0 behaves as 1)
//   O_matcher_arm    arm to the matcher, high only while armed
//   O_trigger        registered trigger output
//   O_armed          high while armed
//   O_busy           high while the pulse train is in progress
//   O_done           one-cycle pulse when a sequence completes
//   O_seq_count      saturating count of completed sequences
//   I_timeout        armed timeout in cycles, 0 disables (PW_TRIG_TIMEOUT_EN)
//   O_timeout        one-cycle pulse on armed timeout (PW_TRIG_TIMEOUT_EN)
interface pw_trigger_sequencer_if #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pWIDTH_WIDTH = 17,
    parameter int pCOUNT_WIDTH = 4
);
    logic                    I_arm;
    logic                    I_match_trigger;
    logic [pDELAY_WIDTH-1:0] I_delay;
    logic [pWIDTH_WIDTH-1:0] I_width;
    logic [pDELAY_WIDTH-1:0] I_gap;
    logic [pCOUNT_WIDTH-1:0] I_num_pulses;
    logic                    O_matcher_arm;
    logic                    O_trigger;
    logic                    O_armed;
    logic                    O_busy;
    logic                    O_done;
    logic [15:0]             O_seq_count;
`ifdef PW_TRIG_TIMEOUT_EN
    logic [31:0]             I_timeout;
    logic                    O_timeout;
    modport master (
        output I_arm, I_match_trigger, I_delay, I_width, I_gap, I_num_pulses, I_timeout,
        input  O_matcher_arm, O_trigger, O_armed, O_busy, O_done, O_seq_count, O_timeout
    );
    modport slave (
        input  I_arm, I_match_trigger, I_delay, I_width, I_gap, I_num_pulses, I_timeout,
        output O_matcher_arm, O_trigger, O_armed, O_busy, O_done, O_seq_count, O_timeout
    );
`else
    modport master (
        output I_arm, I_match_trigger, I_delay, I_width, I_gap, I_num_pulses,
        input  O_matcher_arm, O_trigger, O_armed, O_busy, O_done, O_seq_count
    );
    modport slave (
        input  I_arm, I_match_trigger, I_delay, I_width, I_gap, I_num_pulses,
        output O_matcher_arm, O_trigger, O_armed, O_busy, O_done, O_seq_count
    );
`endif
endinterface

// File: rtl/pw_trigger_sequencer.sv
// pw_trigger_sequencer: arms the pattern matcher and emits a programmable trigger pulse train.
// Optional macro PW_TRIG_TIMEOUT_EN enables an armed-state timeout.
// Ports:
//   fe_clk   the only clock
//   reset_i  synchronous active-high reset
//   bus      pw_trigger_sequencer_if.slave (arm/match inputs, timing config, status outputs)
// Every output comes straight from a flop; outputs are computed alongside each state transition.
module pw_trigger_sequencer #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pWIDTH_WIDTH = 17,
    parameter int pCOUNT_WIDTH = 4
) (
    input logic                  fe_clk,
    input logic                  reset_i,
    pw_trigger_sequencer_if.slave bus
);
    localparam int CW = pDELAY_WIDTH > pWIDTH_WIDTH ? pDELAY_WIDTH : pWIDTH_WIDTH;

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP, DONE} state_t;

    state_t                  state_q;
    logic                    arm_prev_q;
    logic [CW-1:0]           cnt_q;
    logic [pWIDTH_WIDTH-1:0] width_q;
    logic [pDELAY_WIDTH-1:0] gap_q;
    logic [pCOUNT_WIDTH-1:0] num_q;
    logic [pCOUNT_WIDTH-1:0] idx_q;
    logic                    trig_q;
    logic                    marm_q;
    logic                    armed_q;
    logic                    busy_q;
    logic                    done_q;
    logic [15:0]             seq_q;
    logic                    arm_rise;
    logic [pWIDTH_WIDTH-1:0] w_eff;
    logic [pDELAY_WIDTH-1:0] g_eff;
    logic [pCOUNT_WIDTH-1:0] n_eff;
`ifdef PW_TRIG_TIMEOUT_EN
    logic [31:0]             tmo_cnt_q;
    logic                    tmo_q;
    logic                    tmo_fire;
    // Counter holds the number of completed ARMED cycles, so +1 fires on the I_timeout-th cycle.
    assign tmo_fire = bus.I_timeout != '0 && tmo_cnt_q + 32'd1 == bus.I_timeout;
    assign bus.O_timeout = tmo_q;
`endif

    assign arm_rise = bus.I_arm & ~arm_prev_q;
    // Zero-valued width/gap/count behave as one; shadows store the effective values.
    assign w_eff = bus.I_width == '0 ? pWIDTH_WIDTH'(1) : bus.I_width;
    assign g_eff = bus.I_gap == '0 ? pDELAY_WIDTH'(1) : bus.I_gap;
    assign n_eff = bus.I_num_pulses == '0 ? pCOUNT_WIDTH'(1) : bus.I_num_pulses;

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state_q    <= IDLE;
            arm_prev_q <= 1'b0;
            cnt_q      <= '0;
            width_q    <= '0;
            gap_q      <= '0;
            num_q      <= '0;
            idx_q      <= '0;
            trig_q     <= 1'b0;
            marm_q     <= 1'b0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seq_q      <= '0;
`ifdef PW_TRIG_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            arm_prev_q <= bus.I_arm;
            done_q     <= 1'b0;
`ifdef PW_TRIG_TIMEOUT_EN
            tmo_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (arm_rise) begin
                        state_q <= ARMED;
                        marm_q  <= 1'b1;
                        armed_q <= 1'b1;
`ifdef PW_TRIG_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                ARMED: begin
`ifdef PW_TRIG_TIMEOUT_EN
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
`endif
                    // Abort beats a simultaneous match.
                    if (!bus.I_arm) begin
                        state_q <= IDLE;
                        marm_q  <= 1'b0;
                        armed_q <= 1'b0;
                    end else if (bus.I_match_trigger) begin
                        width_q <= w_eff;
                        gap_q   <= g_eff;
                        num_q   <= n_eff;
                        idx_q   <= '0;
                        marm_q  <= 1'b0;
                        armed_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (bus.I_delay == '0) begin
                            state_q <= PULSE;
                            cnt_q   <= CW'(w_eff - 1'b1);
                            trig_q  <= 1'b1;
                        end else begin
                            state_q <= DELAY;
                            cnt_q   <= CW'(bus.I_delay - 1'b1);
                        end
                    end
`ifdef PW_TRIG_TIMEOUT_EN
                    else if (tmo_fire) begin
                        state_q <= IDLE;
                        marm_q  <= 1'b0;
                        armed_q <= 1'b0;
                        tmo_q   <= 1'b1;
                    end
`endif
                end
                DELAY, GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= PULSE;
                        cnt_q   <= CW'(width_q - 1'b1);
                        trig_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        idx_q  <= idx_q + 1'b1;
                        trig_q <= 1'b0;
                        if (idx_q + 1'b1 == num_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            seq_q   <= seq_q == 16'hFFFF ? seq_q : seq_q + 16'd1;
                        end else begin
                            state_q <= GAP;
                            cnt_q   <= CW'(gap_q - 1'b1);
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.O_matcher_arm = marm_q;
    assign bus.O_trigger     = trig_q;
    assign bus.O_armed       = armed_q;
    assign bus.O_busy        = busy_q;
    assign bus.O_done        = done_q;
    assign bus.O_seq_count   = seq_q;
endmodule

// File: tb/tb_pw_trigger_sequencer.sv
// tb_pw_trigger_sequencer: randomized self-checking bench against an arithmetic pulse-train model.
module tb_pw_trigger_sequencer;
    localparam int DW = 20;
    localparam int WW = 17;
    localparam int NW = 4;

    logic fe_clk = 1'b0;
    logic reset_i;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_seq = 0;

    pw_trigger_sequencer_if #(.pDELAY_WIDTH(DW), .pWIDTH_WIDTH(WW), .pCOUNT_WIDTH(NW)) bus ();

    pw_trigger_sequencer #(.pDELAY_WIDTH(DW), .pWIDTH_WIDTH(WW), .pCOUNT_WIDTH(NW)) dut (
        .fe_clk  (fe_clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 fe_clk = ~fe_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge fe_clk);
        #1;
    endtask

    // Trigger level k edges after the match edge, from the delay/width/gap/count rules.
    function automatic bit exp_trig(input int k, input int d, input int w, input int g, input int p);
        int t;
        t = k - d;
        if (t < 0) return 1'b0;
        if (t / (w + g) >= p) return 1'b0;
        return (t % (w + g)) < w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_trig"}, bus.O_trigger, 0);
        check({tag, "_armed"}, bus.O_armed, 0);
        check({tag, "_marm"}, bus.O_matcher_arm, 0);
        check({tag, "_busy"}, bus.O_busy, 0);
        check({tag, "_done"}, bus.O_done, 0);
        check({tag, "_seq"}, bus.O_seq_count, 0);
    endtask

    task automatic run_seq(input int d, input int w, input int g, input int p,
                           input bit abort, input int drop_at, input int rst_at, input int wait_cyc);
        int we;
        int ge;
        int pe;
        int t_end;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        pe = (p == 0) ? 1 : p;
        t_end = d + pe * we + (pe - 1) * ge;
        bus.I_arm = 1'b0;
        bus.I_match_trigger = 1'b1;
        step();
        check("idle_armed", bus.O_armed, 0);
        check("idle_trig", bus.O_trigger, 0);
        bus.I_match_trigger = 1'b0;
        bus.I_arm = 1'b1;
        step();
        check("arm_armed", bus.O_armed, 1);
        check("arm_marm", bus.O_matcher_arm, 1);
        check("arm_busy", bus.O_busy, 0);
        repeat (wait_cyc) step();
        check("arm_hold", bus.O_armed, 1);
        bus.I_delay = DW'(d);
        bus.I_width = WW'(w);
        bus.I_gap = DW'(g);
        bus.I_num_pulses = NW'(p);
        bus.I_match_trigger = 1'b1;
        if (abort) bus.I_arm = 1'b0;
        step();
        bus.I_match_trigger = 1'b0;
        if (abort) begin
            for (int k = 0; k < 3; k++) begin
                check("abort_armed", bus.O_armed, 0);
                check("abort_marm", bus.O_matcher_arm, 0);
                check("abort_busy", bus.O_busy, 0);
                check("abort_trig", bus.O_trigger, 0);
                step();
            end
            return;
        end
        for (int k = 0; k <= t_end + 2; k++) begin
            if (k == rst_at) begin
                reset_i = 1'b1;
                bus.I_arm = 1'b0;
                step();
                reset_i = 1'b0;
                exp_seq = 0;
                check_reset_outputs("midrst");
                return;
            end
            if (k == t_end) exp_seq = (exp_seq == 65535) ? 65535 : exp_seq + 1;
            check("seq_trig", bus.O_trigger, exp_trig(k, d, we, ge, pe));
            check("seq_busy", bus.O_busy, k < t_end);
            check("seq_done", bus.O_done, k == t_end);
            check("seq_armed", bus.O_armed, 0);
            check("seq_marm", bus.O_matcher_arm, 0);
            check("seq_count", bus.O_seq_count, exp_seq[15:0]);
            // Config churn and stray matches after the match must have no effect.
            bus.I_width = WW'($urandom_range(0, 15));
            bus.I_gap = DW'($urandom_range(0, 15));
            bus.I_delay = DW'($urandom_range(0, 15));
            bus.I_num_pulses = NW'($urandom_range(0, 15));
            bus.I_match_trigger = ($urandom_range(0, 3) == 0);
            if (k == drop_at) bus.I_arm = 1'b0;
            step();
        end
        bus.I_match_trigger = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        bus.I_arm = 1'b0;
        bus.I_match_trigger = 1'b0;
        bus.I_delay = '0;
        bus.I_width = '0;
        bus.I_gap = '0;
        bus.I_num_pulses = '0;
`ifdef PW_TRIG_TIMEOUT_EN
        bus.I_timeout = '0;
`endif
        step();
        step();
        check_reset_outputs("reset");
        reset_i = 1'b0;
        step();
        run_seq(0, 1, 0, 1, 1'b0, -1, -1, 0);
        run_seq(5, 3, 2, 3, 1'b0, -1, -1, 2);
        run_seq(5, 3, 2, 3, 1'b0, 2, -1, 1);
        run_seq(1, 2, 1, 2, 1'b1, -1, -1, 1);
        run_seq(2, 4, 1, 2, 1'b0, -1, 3, 0);
        run_seq(0, 0, 0, 0, 1'b0, -1, -1, 0);
        for (int i = 0; i < 120; i++) begin
            run_seq($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 5), $urandom_range(0, 7) == 0,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1,
                    ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 10)) : -1,
                    $urandom_range(0, 3));
        end
        force dut.seq_q = 16'hFFFE;
        step();
        release dut.seq_q;
        exp_seq = 65534;
        run_seq(1, 2, 1, 2, 1'b0, -1, -1, 0);
        run_seq(0, 1, 1, 1, 1'b0, -1, -1, 0);
        run_seq(2, 1, 1, 3, 1'b0, -1, -1, 0);
`ifdef PW_TRIG_TIMEOUT_EN
        bus.I_arm = 1'b0;
        bus.I_timeout = 32'd100;
        step();
        bus.I_arm = 1'b1;
        step();
        for (int j = 1; j <= 100; j++) begin
            step();
            check("tmo_pulse", bus.O_timeout, j == 100);
            check("tmo_armed", bus.O_armed, j < 100);
        end
        step();
        check("tmo_clear", bus.O_timeout, 0);
        check("tmo_seq", bus.O_seq_count, exp_seq[15:0]);
        bus.I_arm = 1'b0;
        bus.I_timeout = '0;
        step();
        bus.I_arm = 1'b1;
        repeat (150) step();
        check("tmo_off_armed", bus.O_armed, 1);
        check("tmo_off_pulse", bus.O_timeout, 0);
        bus.I_arm = 1'b0;
        step();
        step();
        check("tmo_off_abort", bus.O_armed, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
